// File: rtl/puzzle_board_ctrl.sv
// rtl/puzzle_board_ctrl.sv - sliding-puzzle board owner: init, shuffle, player moves, solved detect, tile read port
// Define MOVE_COUNT_EN to build the player move counter; otherwise move_count is tied to 0.
module puzzle_board_ctrl #(
   parameter int unsigned SHUFFLE_MOVES = 256,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  board_size,
   input  logic        is_game_on,
   input  logic        click,
   input  logic [1:0]  click_row,
   input  logic [1:0]  click_col,
   input  logic [1:0]  rd_row,
   input  logic [1:0]  rd_col,
   output logic [3:0]  rd_tile,
   output logic        busy,
   output logic        solved,
   output logic [15:0] move_count
);
   typedef enum logic [2:0] {
      S_IDLE, S_INIT, S_SHUFFLE, S_PLAY, S_SWAP, S_CHECK, S_SOLVED
   } state_t;

   state_t      state, state_next;
   logic [3:0]  cells [16];
   logic [1:0]  br, bc, sel_r, sel_c;
   logic [2:0]  n, n_req;
   logic [15:0] shuf_cnt, lfsr;
   logic        lfsr_fb, abort;
   logic [1:0]  tr, tc;
   logic        t_ok, click_in, click_adj, click_ok, board_ok;

   assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
   assign abort    = (state != S_IDLE) && !is_game_on;
   assign busy     = (state == S_INIT) || (state == S_SHUFFLE) || (state == S_SWAP) || (state == S_CHECK);
   assign solved   = (state == S_SOLVED);

   always_comb begin
      n_req = board_size;
      if (board_size < 3'd2)
         n_req = 3'd2;
      else if (board_size > 3'd4)
         n_req = 3'd4;
   end

   // Shuffle candidate: neighbour of the blank in the LFSR-selected direction.
   always_comb begin
      tr   = br;
      tc   = bc;
      t_ok = 1'b0;
      case (lfsr[1:0])
         2'd0: begin tr = br - 2'd1; t_ok = (br != 2'd0); end
         2'd1: begin tr = br + 2'd1; t_ok = (({1'b0, br} + 3'd1) < n); end
         2'd2: begin tc = bc - 2'd1; t_ok = (bc != 2'd0); end
         default: begin tc = bc + 2'd1; t_ok = (({1'b0, bc} + 3'd1) < n); end
      endcase
   end

   // 3-bit arithmetic so coordinate 3 never wraps to 0 when testing adjacency.
   assign click_in  = ({1'b0, click_row} < n) && ({1'b0, click_col} < n);
   assign click_adj = ((click_row == br) &&
                       (({1'b0, click_col} == {1'b0, bc} + 3'd1) || ({1'b0, click_col} + 3'd1 == {1'b0, bc}))) ||
                      ((click_col == bc) &&
                       (({1'b0, click_row} == {1'b0, br} + 3'd1) || ({1'b0, click_row} + 3'd1 == {1'b0, br})));
   assign click_ok  = click && click_in && click_adj;

   always_comb begin
      board_ok = ({1'b0, br} == n - 3'd1) && ({1'b0, bc} == n - 3'd1);
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if ((3'(r) < n) && (3'(c) < n) && !((3'(r) == n - 3'd1) && (3'(c) == n - 3'd1)) &&
                (cells[r*4+c] != 4'(r * int'(n) + c + 1)))
               board_ok = 1'b0;
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:    if (is_game_on) state_next = S_INIT;
         S_INIT:    state_next = S_SHUFFLE;
         S_SHUFFLE: if ((shuf_cnt == 16'd0) && !board_ok) state_next = S_PLAY;
         S_PLAY:    if (click_ok) state_next = S_SWAP;
         S_SWAP:    state_next = S_CHECK;
         S_CHECK:   state_next = board_ok ? S_SOLVED : S_PLAY;
         S_SOLVED:  state_next = S_SOLVED;
         default:   state_next = S_IDLE;
      endcase
      if (abort)
         state_next = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         lfsr     <= LFSR_SEED;
         rd_tile  <= 4'd0;
         n        <= 3'd2;
         br       <= 2'd0;
         bc       <= 2'd0;
         sel_r    <= 2'd0;
         sel_c    <= 2'd0;
         shuf_cnt <= 16'd0;
         for (int i = 0; i < 16; i++)
            cells[i] <= 4'd0;
      end else begin
         state   <= state_next;
         lfsr    <= {lfsr[14:0], lfsr_fb};
         rd_tile <= cells[{rd_row, rd_col}];
         if (!abort) begin
            case (state)
               S_IDLE: if (is_game_on) n <= n_req;
               S_INIT: begin
                  for (int r = 0; r < 4; r++) begin
                     for (int c = 0; c < 4; c++) begin
                        if ((3'(r) < n) && (3'(c) < n) && !((3'(r) == n - 3'd1) && (3'(c) == n - 3'd1)))
                           cells[r*4+c] <= 4'(r * int'(n) + c + 1);
                        else
                           cells[r*4+c] <= 4'd0;
                     end
                  end
                  br       <= 2'(n - 3'd1);
                  bc       <= 2'(n - 3'd1);
                  shuf_cnt <= 16'(SHUFFLE_MOVES);
               end
               S_SHUFFLE: begin
                  if (shuf_cnt == 16'd0) begin
                     // A shuffle that lands back on the solution keeps going one move at a time.
                     if (board_ok)
                        shuf_cnt <= 16'd1;
                  end else if (t_ok) begin
                     cells[{br, bc}] <= cells[{tr, tc}];
                     cells[{tr, tc}] <= 4'd0;
                     br       <= tr;
                     bc       <= tc;
                     shuf_cnt <= shuf_cnt - 16'd1;
                  end
               end
               S_PLAY: begin
                  if (click_ok) begin
                     sel_r <= click_row;
                     sel_c <= click_col;
                  end
               end
               S_SWAP: begin
                  cells[{br, bc}]       <= cells[{sel_r, sel_c}];
                  cells[{sel_r, sel_c}] <= 4'd0;
                  br <= sel_r;
                  bc <= sel_c;
               end
               default: ;
            endcase
         end
      end
   end

`ifdef MOVE_COUNT_EN
   logic [15:0] move_cnt;

   always_ff @(posedge clk) begin
      if (rst)
         move_cnt <= 16'd0;
      else if ((state == S_IDLE) && is_game_on)
         move_cnt <= 16'd0;
      else if ((state == S_SWAP) && !abort && (move_cnt != 16'hFFFF))
         move_cnt <= move_cnt + 16'd1;
   end

   assign move_count = move_cnt;
`else
   assign move_count = 16'd0;
`endif

endmodule

// File: tb/tb_puzzle_board_ctrl.sv
// tb/tb_puzzle_board_ctrl.sv - self-checking bench for puzzle_board_ctrl against a board-level reference model
module tb_puzzle_board_ctrl;
   localparam int SHUF = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  board_size;
   logic        is_game_on;
   logic        click;
   logic [1:0]  click_row, click_col, rd_row, rd_col;
   logic [3:0]  rd_tile;
   logic        busy, solved;
   logic [15:0] move_count;

   always #5 clk = ~clk;

   puzzle_board_ctrl #(.SHUFFLE_MOVES(SHUF), .LFSR_SEED(16'hACE1)) dut (
      .clk(clk), .rst(rst), .board_size(board_size), .is_game_on(is_game_on),
      .click(click), .click_row(click_row), .click_col(click_col),
      .rd_row(rd_row), .rd_col(rd_col), .rd_tile(rd_tile),
      .busy(busy), .solved(solved), .move_count(move_count)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int mb [16];
   int mn, mbr, mbc, mmoves;
   bit msolved;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic int exp_mc();
`ifdef MOVE_COUNT_EN
      return (mmoves > 65535) ? 65535 : mmoves;
`else
      return 0;
`endif
   endfunction

   function automatic void model_init(input int nn);
      for (int i = 0; i < 16; i++) mb[i] = 0;
      for (int r = 0; r < nn; r++)
         for (int c = 0; c < nn; c++)
            mb[r*4+c] = (r == nn-1 && c == nn-1) ? 0 : r*nn + c + 1;
      mbr = nn - 1;
      mbc = nn - 1;
   endfunction

   function automatic bit model_solved();
      if (mbr != mn-1 || mbc != mn-1) return 1'b0;
      for (int r = 0; r < mn; r++)
         for (int c = 0; c < mn; c++)
            if (!(r == mn-1 && c == mn-1) && mb[r*4+c] != r*mn + c + 1) return 1'b0;
      return 1'b1;
   endfunction

   task automatic read_cell(input int r, input int c, output int v);
      rd_row = 2'(r);
      rd_col = 2'(c);
      step();
      v = int'(rd_tile);
   endtask

   task automatic check_board(input string tag);
      int v;
      for (int i = 0; i < 16; i++) begin
         read_cell(i / 4, i % 4, v);
         check($sformatf("%s_cell%0d", tag, i), v, mb[i]);
      end
   endtask

   task automatic wait_ready(input string tag);
      int k = 0;
      while (busy === 1'b1 && k < 2000) begin
         step();
         k++;
      end
      check({tag, "_ready"}, busy, 0);
   endtask

   // With one shuffle move the board is the solution with the blank moved up or left once.
   task automatic take_shuffle(input string tag);
      int obs [16];
      int zr = -1, zc = -1;
      for (int i = 0; i < 16; i++) read_cell(i / 4, i % 4, obs[i]);
      for (int i = 0; i < 16; i++)
         if (obs[i] == 0 && (i / 4) < mn && (i % 4) < mn && zr < 0) begin
            zr = i / 4;
            zc = i % 4;
         end
      model_init(mn);
      if (zr == mn-1 && zc == mn-2) begin
         mb[mbr*4+mbc] = mb[mbr*4+mbc-1];
         mb[mbr*4+mbc-1] = 0;
         mbc = mbc - 1;
      end else begin
         mb[mbr*4+mbc] = mb[(mbr-1)*4+mbc];
         mb[(mbr-1)*4+mbc] = 0;
         mbr = mbr - 1;
      end
      for (int i = 0; i < 16; i++)
         check($sformatf("%s_shuf_cell%0d", tag, i), obs[i], mb[i]);
      if (mn == 4) begin
         for (int v = 0; v < 16; v++) begin
            int cnt = 0;
            for (int i = 0; i < 16; i++) if (obs[i] == v) cnt++;
            check($sformatf("%s_perm_val%0d", tag, v), cnt, 1);
         end
      end
   endtask

   task automatic start_game(input logic [2:0] bs, input string tag);
      board_size = bs;
      is_game_on = 1'b1;
      step();
      check({tag, "_init_busy"}, busy, 1);
      mn = (bs < 2) ? 2 : (bs > 4) ? 4 : int'(bs);
      mmoves = 0;
      msolved = 1'b0;
      wait_ready(tag);
      check({tag, "_start_mc"}, move_count, 0);
      check({tag, "_start_solved"}, solved, 0);
      take_shuffle(tag);
   endtask

   task automatic end_game(input string tag);
      is_game_on = 1'b0;
      step();
      check({tag, "_end_busy"}, busy, 0);
      check({tag, "_end_solved"}, solved, 0);
   endtask

   task automatic do_click(input int r, input int c, input string tag);
      bit legal;
      int d;
      d = ((r > mbr) ? r - mbr : mbr - r) + ((c > mbc) ? c - mbc : mbc - c);
      legal = !msolved && r < mn && c < mn && d == 1;
      click_row = 2'(r);
      click_col = 2'(c);
      click = 1'b1;
      step();
      click = 1'b0;
      check({tag, "_swap_busy"}, busy, legal);
      step();
      step();
      if (legal) begin
         mb[mbr*4+mbc] = mb[r*4+c];
         mb[r*4+c] = 0;
         mbr = r;
         mbc = c;
         mmoves++;
         msolved = model_solved();
      end
      check({tag, "_solved"}, solved, msolved);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_mc"}, move_count, exp_mc());
      check_board(tag);
   endtask

   task automatic random_clicks(input int count, input string tag);
      int r, c;
      for (int k = 0; k < count; k++) begin
         if ($urandom_range(0, 2) == 0) begin
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
         end else begin
            r = mbr;
            c = mbc;
            case ($urandom_range(0, 3))
               0: r = (mbr + 3) % 4;
               1: r = (mbr + 1) % 4;
               2: c = (mbc + 3) % 4;
               default: c = (mbc + 1) % 4;
            endcase
         end
         board_size = 3'($urandom_range(0, 7));
         do_click(r, c, $sformatf("%s_rc%0d", tag, k));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int v;
      rst = 1'b1;
      board_size = 3'd0;
      is_game_on = 1'b0;
      click = 1'b0;
      click_row = 2'd0;
      click_col = 2'd0;
      rd_row = 2'd0;
      rd_col = 2'd0;
      @(negedge clk);
      step();
      step();
      rst = 1'b0;

      for (int k = 0; k < 10; k++) begin
         rd_row = 2'($urandom_range(0, 3));
         rd_col = 2'($urandom_range(0, 3));
         step();
         check($sformatf("rst_rd%0d", k), rd_tile, 0);
         check($sformatf("rst_busy%0d", k), busy, 0);
         check($sformatf("rst_solved%0d", k), solved, 0);
         check($sformatf("rst_mc%0d", k), move_count, 0);
      end

      // 2x2: one corrective click solves it.
      start_game(3'd2, "n2");
      do_click(1, 1, "n2_fix");
      check("n2_solved_flag", solved, 1);
      read_cell(0, 0, v); check("n2_r00", v, 1);
      read_cell(0, 1, v); check("n2_r01", v, 2);
      read_cell(1, 0, v); check("n2_r10", v, 3);
      read_cell(1, 1, v); check("n2_r11", v, 0);
      do_click(0, 1, "n2_after_solved");
      end_game("n2");

      // 3x3: distance-2 and out-of-bounds clicks are ignored.
      start_game(3'd3, "n3");
      if (mbc >= 2) do_click(mbr, mbc - 2, "n3_dist2");
      else          do_click(mbr - 2, mbc, "n3_dist2");
      do_click(3, 3, "n3_oob");
      do_click(mbr, mbc, "n3_self");
      random_clicks(30, "n3");
      end_game("n3");

      // board_size 7 clamps to 4x4.
      start_game(3'd7, "n7");
      random_clicks(40, "n7");
      end_game("n7");

      // board_size 0 clamps to 2x2; row/col 2 read as 0.
      start_game(3'd0, "n0");
      for (int i = 0; i < 4; i++) begin
         read_cell(2, i, v); check($sformatf("n0_row2_%0d", i), v, 0);
         read_cell(i, 2, v); check($sformatf("n0_col2_%0d", i), v, 0);
      end
      random_clicks(20, "n0");
      end_game("n0");

      // Abort in the first shuffle cycle leaves the freshly initialised board.
      board_size = 3'd3;
      is_game_on = 1'b1;
      step();
      step();
      check("abort_shuffle_busy", busy, 1);
      is_game_on = 1'b0;
      step();
      check("abort_busy", busy, 0);
      check("abort_solved", solved, 0);
      mn = 3;
      model_init(3);
      check_board("abort_board");
      start_game(3'd4, "restart");
      random_clicks(15, "restart");
      end_game("restart");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
